// File: rtl/status_commit_pipe_pkg.sv
// Processor-wide status definitions shared by the execute/commit path.
// Overflow codes are the values assign_status writes for an arithmetic exception.
package status_commit_pipe_pkg;

    localparam int STATUS_W = 27;

    localparam logic [STATUS_W-1:0] EXC_ADD  = STATUS_W'(1);
    localparam logic [STATUS_W-1:0] EXC_ADDI = STATUS_W'(2);
    localparam logic [STATUS_W-1:0] EXC_SUB  = STATUS_W'(3);

endpackage

// File: rtl/status_commit_pipe_status_slot.sv
// One pipeline slot carrying a pending status write (valid, exception flag, data).
// Holds its contents while hold is high; cleared asynchronously by reset.
module status_slot #(
    parameter int W = status_commit_pipe_pkg::STATUS_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         hold,
    input  logic         d_valid,
    input  logic         d_exc,
    input  logic [W-1:0] d_data,
    output logic         q_valid,
    output logic         q_exc,
    output logic [W-1:0] q_data
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_valid <= 1'b0;
            q_exc   <= 1'b0;
            q_data  <= '0;
        end else if (!hold) begin
            q_valid <= d_valid;
            q_exc   <= d_exc;
            q_data  <= d_data;
        end
    end

endmodule

// File: rtl/status_commit_pipe.sv
// Carries assign_status writes through X/M and M/W, commits them to rstatus at
// writeback, counts committed exceptions, and forwards the youngest status to bex.
module status_commit_pipe #(
    parameter int STATUS_W = status_commit_pipe_pkg::STATUS_W,
    parameter int CNT_W    = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ex_valid,
    input  logic                ex_status_we,
    input  logic                ex_is_exc,
    input  logic [STATUS_W-1:0] ex_status_in,
    input  logic                stall,
    input  logic                flush_xm,
    input  logic                bex_query,
    output logic                bex_taken,
    output logic [STATUS_W-1:0] bex_target,
    output logic [STATUS_W-1:0] status_q,
    output logic [CNT_W-1:0]    exc_count
);

    logic                xm_valid, xm_exc;
    logic [STATUS_W-1:0] xm_data;
    logic                mw_valid, mw_exc;
    logic [STATUS_W-1:0] mw_data;
    logic                xm_capture;
    logic [STATUS_W-1:0] fwd;

    // Stall freezes the slot, so a flush raised during a stall has no effect.
    assign xm_capture = ex_valid & ex_status_we & ~flush_xm;

    status_slot #(.W(STATUS_W)) u_xm (
        .clock   (clock),
        .reset   (reset),
        .hold    (stall),
        .d_valid (xm_capture),
        .d_exc   (ex_is_exc),
        .d_data  (ex_status_in),
        .q_valid (xm_valid),
        .q_exc   (xm_exc),
        .q_data  (xm_data)
    );

    status_slot #(.W(STATUS_W)) u_mw (
        .clock   (clock),
        .reset   (reset),
        .hold    (stall),
        .d_valid (xm_valid),
        .d_exc   (xm_exc),
        .d_data  (xm_data),
        .q_valid (mw_valid),
        .q_exc   (mw_exc),
        .q_data  (mw_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            status_q  <= '0;
            exc_count <= '0;
        end else if (!stall && mw_valid) begin
            status_q <= mw_data;
            if (mw_exc && (exc_count != {CNT_W{1'b1}})) begin
                exc_count <= exc_count + CNT_W'(1);
            end
        end
    end

    // Youngest in-flight write wins; the same-cycle ex write is never forwarded.
    always_comb begin
        fwd = status_q;
        if (xm_valid) begin
            fwd = xm_data;
        end else if (mw_valid) begin
            fwd = mw_data;
        end
    end

    assign bex_target = fwd;
    assign bex_taken  = bex_query & (fwd != '0);

endmodule

// File: tb/tb_status_commit_pipe.sv
// Directed bench for status_commit_pipe: queue-based reference model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_status_commit_pipe;
    import status_commit_pipe_pkg::*;

    localparam int SW = STATUS_W;
    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          ex_valid = 1'b0;
    logic          ex_status_we = 1'b0;
    logic          ex_is_exc = 1'b0;
    logic [SW-1:0] ex_status_in = '0;
    logic          stall = 1'b0;
    logic          flush_xm = 1'b0;
    logic          bex_query = 1'b0;
    logic          bex_taken;
    logic [SW-1:0] bex_target;
    logic [SW-1:0] status_q;
    logic [CW-1:0] exc_count;

    int n_total = 0;
    int n_pass  = 0;

    status_commit_pipe #(.STATUS_W(SW), .CNT_W(CW)) dut (
        .clock        (clock),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_status_we (ex_status_we),
        .ex_is_exc    (ex_is_exc),
        .ex_status_in (ex_status_in),
        .stall        (stall),
        .flush_xm     (flush_xm),
        .bex_query    (bex_query),
        .bex_taken    (bex_taken),
        .bex_target   (bex_target),
        .status_q     (status_q),
        .exc_count    (exc_count)
    );

    // clock / reset
    always #5 clock = ~clock;

    // reference model: in-flight writes in age order (youngest first)
    typedef struct {
        bit            v;
        bit            e;
        logic [SW-1:0] d;
    } item_t;

    item_t         inflight[$];
    logic [SW-1:0] m_status;
    int            m_count;

    task automatic model_clear();
        item_t empty;
        empty.v = 1'b0;
        empty.e = 1'b0;
        empty.d = '0;
        inflight.delete();
        inflight.push_back(empty);
        inflight.push_back(empty);
        m_status = '0;
        m_count  = 0;
    endtask

    function automatic logic [SW-1:0] model_fwd();
        foreach (inflight[i]) begin
            if (inflight[i].v) return inflight[i].d;
        end
        return m_status;
    endfunction

    initial model_clear();

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            model_clear();
        end else if (!stall) begin
            item_t nw;
            item_t old;
            nw.v = ex_valid && ex_status_we && !flush_xm;
            nw.e = ex_is_exc;
            nw.d = ex_status_in;
            inflight.push_front(nw);
            old = inflight.pop_back();
            if (old.v) begin
                m_status = old.d;
                if (old.e) m_count = (m_count + 1 > 255) ? 255 : m_count + 1;
            end
        end
    end

    // scoreboard
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            logic [SW-1:0] f;
            f = model_fwd();
            check("model_status_q", 32'(status_q), 32'(m_status));
            check("model_exc_count", 32'(exc_count), 32'(m_count));
            check("model_bex_target", 32'(bex_target), 32'(f));
            check("model_bex_taken", 32'(bex_taken), 32'(bex_query && (f != '0)));
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic e, input logic [SW-1:0] d,
                         input logic st, input logic fl, input logic bq);
        ex_valid     = v;
        ex_status_we = we;
        ex_is_exc    = e;
        ex_status_in = d;
        stall        = st;
        flush_xm     = fl;
        bex_query    = bq;
        #1;
    endtask

    task automatic idle(input logic bq);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, bq);
    endtask

    task automatic setx(input logic [SW-1:0] d);
        drive(1'b1, 1'b1, 1'b0, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic exc_wr(input logic [SW-1:0] d);
        drive(1'b1, 1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2;
        check("reset_status_q", 32'(status_q), 0);
        check("reset_exc_count", 32'(exc_count), 0);
        check("reset_bex_target", 32'(bex_target), 0);
        check("reset_bex_taken", 32'(bex_taken), 0);
        tick();
        reset = 1'b0;
        tick();

        // commit latency and setx forwarding
        setx(SW'(241));
        tick();
        idle(1'b1);
        check("fwd_c1_taken", 32'(bex_taken), 1);
        check("fwd_c1_target", 32'(bex_target), 241);
        check("fwd_c1_status", 32'(status_q), 0);
        tick();
        check("fwd_c2_target", 32'(bex_target), 241);
        check("fwd_c2_status", 32'(status_q), 0);
        tick();
        check("fwd_c3_taken", 32'(bex_taken), 1);
        check("fwd_c3_status", 32'(status_q), 241);
        tick();
        idle(1'b0);

        // exception counting
        exc_wr(EXC_ADD);
        tick();
        exc_wr(EXC_SUB);
        tick();
        idle(1'b0);
        tick();
        check("exc_status_first", 32'(status_q), 1);
        tick();
        check("exc_status_second", 32'(status_q), 3);
        check("exc_count_two", 32'(exc_count), 2);

        // youngest wins
        setx(SW'(7));
        tick();
        setx(SW'(0));
        tick();
        idle(1'b1);
        check("young_taken", 32'(bex_taken), 0);
        check("young_target", 32'(bex_target), 0);
        tick();
        tick();
        check("young_status", 32'(status_q), 0);
        idle(1'b0);

        // flush
        drive(1'b1, 1'b1, 1'b0, SW'(5), 1'b0, 1'b1, 1'b0);
        tick();
        idle(1'b1);
        check("flush_taken", 32'(bex_taken), 0);
        tick();
        tick();
        check("flush_status", 32'(status_q), 0);
        idle(1'b0);

        // stall holds an in-flight write
        setx(SW'(9));
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
            tick();
            check("stall_hold_status", 32'(status_q), 0);
        end
        idle(1'b0);
        tick();
        check("stall_release_1", 32'(status_q), 0);
        tick();
        check("stall_commit", 32'(status_q), 9);

        // stall has priority over flush
        setx(SW'(12));
        tick();
        drive(1'b1, 1'b1, 1'b0, SW'(11), 1'b1, 1'b1, 1'b0);
        tick();
        idle(1'b1);
        check("stallflush_fwd", 32'(bex_target), 12);
        idle(1'b0);
        tick();
        tick();
        check("stallflush_commit", 32'(status_q), 12);
        tick();
        check("stallflush_no_11", 32'(status_q), 12);

        // bubble with ex_status_we low never writes
        drive(1'b1, 1'b0, 1'b0, SW'(77), 1'b0, 1'b0, 1'b0);
        tick();
        idle(1'b0);
        tick();
        tick();
        check("bubble_status", 32'(status_q), 12);

        // saturation
        for (int i = 0; i < 260; i++) begin
            exc_wr((i % 2 == 0) ? EXC_ADD : EXC_ADDI);
            tick();
        end
        exc_wr(EXC_ADD);
        tick();
        idle(1'b0);
        tick();
        tick();
        check("sat_count", 32'(exc_count), 255);
        check("sat_status", 32'(status_q), 1);

        // asynchronous reset with writes in flight
        setx(SW'(100));
        tick();
        setx(SW'(200));
        tick();
        idle(1'b1);
        reset = 1'b1;
        #1;
        check("arst_status", 32'(status_q), 0);
        check("arst_count", 32'(exc_count), 0);
        check("arst_target", 32'(bex_target), 0);
        check("arst_taken", 32'(bex_taken), 0);
        tick();
        #1;
        reset = 1'b0;
        idle(1'b0);
        for (int i = 0; i < 4; i++) tick();
        check("arst_no_commit", 32'(status_q), 0);
        check("arst_no_count", 32'(exc_count), 0);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
